out_data_sig_capture: RTL and testbench
=======================================

Name: out_data_sig_capture

Overview:
- Downstream consumer of the 96-bit combinational `out_data` produced by a generated `top` cell under test.
- Registers each presented result vector and compresses a run of N vectors into a 32-bit MISR signature.
- Reports the final signature, so simulator runs can be compared by a single word instead of full traces.
- Sits between the DUT output bus and the bench/scoreboard, and adds the only sequential state in that path.

Parameters:
- DATA_W, 96, width of the consumed result bus; zero-padded at the top to a multiple of SIG_W before folding.
- SIG_W, 32, signature width.
- POLY, 32'h04C11DB7, MISR feedback polynomial (Galois form).
- SEED, 32'hFFFFFFFF, signature value loaded on reset and on start.
- CNT_W, 16, width of vector-count target and counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a capture run.
- num_vecs  in  CNT_W  number of vectors in the run; sampled when start is accepted.
- in_valid  in  1  result vector present on in_data.
- in_data  in  DATA_W  result bus (the DUT's out_data).
- in_ready  out  1  block accepts a vector this cycle.
- vec_cnt  out  CNT_W  vectors accepted in the current run.
- busy  out  1  run in progress.
- done  out  1  run complete; signature final.
- sig  out  SIG_W  current signature.

Behaviour:
- Reset, checked first every cycle, overriding all inputs:
  - state=IDLE; sig=SEED; vec_cnt=0; busy=0; done=0; in_ready=0.
  - Reset mid-run discards the run; no partial done is produced.
- States: IDLE, ACCUM, DONE. All outputs are registered or derived only from state (in_ready=busy=(state==ACCUM); done=(state==DONE)).
- IDLE, on start=1:
  - Latch num_vecs into target; load sig=SEED; vec_cnt=0.
  - Next state ACCUM, or DONE directly if num_vecs==0.
- ACCUM:
  - Accept a vector iff in_valid & in_ready.
  - On accept: fold = XOR of the SIG_W-bit slices of zero-padded in_data (96-bit: in_data[31:0]^in_data[63:32]^in_data[95:64]).
  - On accept: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold; vec_cnt <= vec_cnt+1.
  - When the accepted vector makes vec_cnt+1==target: next state DONE. done=1 in the cycle after the edge that accepted the last vector, and sig is already final in that cycle.
  - No accept means sig and vec_cnt hold.
  - start in ACCUM is ignored; the run is not restarted.
- DONE:
  - sig and vec_cnt hold; in_ready=0; in_valid ignored.
  - start=1 begins a new run exactly as from IDLE (reseed, clear count); done drops the next cycle.
- IDLE and DONE: in_valid is ignored and nothing updates; the upstream is held off by in_ready=0.
- Counter arithmetic: unsigned CNT_W. The target is reached before wrap, so num_vecs=2^CNT_W-1 is the maximum run.
- Latency: start at edge k gives in_ready=1 from cycle k+1. One vector per cycle sustained, no bubbles.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release -> sig=32'hFFFFFFFF, vec_cnt=0, in_ready=0, done=0. in_valid=1 with in_data=96'h5 in IDLE -> sig unchanged.
- Single zero vector: start with num_vecs=1, then in_data=0 with in_valid=1 -> sig=32'hFB3EE249, vec_cnt=1, done=1 one cycle after accept, in_ready=0.
- Fold/shift check with SEED=0: num_vecs=2, vectors 96'h1 then 96'h0 -> sig=32'h1 after the first and 32'h2 after the second, then done. Vector {32'hA,32'hA,32'h3} as the first -> sig=32'hA^32'hA^32'h3=32'h3.
- Gapped input and ignored start: num_vecs=3, in_valid toggled 1,0,1,0,1 with start pulsed in the gaps -> exactly 3 accepts, vec_cnt=3. The signature equals the gap-free run on the same data.
- Zero-length and restart: num_vecs=0 -> done the cycle after start, sig=SEED. Then start with num_vecs=1 from DONE -> done drops, in_ready=1, next vector accepted.
- Reset mid-run: assert rst after 2 of 5 vectors -> IDLE, sig=SEED, vec_cnt=0, done never asserted; a subsequent full run matches a clean run.

Source files
------------

// File: rtl/out_data_sig_capture.sv
// out_data_sig_capture
//   Consumes the 96-bit combinational result bus of a cell under test and
//   compresses a run of num_vecs accepted vectors into a 32-bit Galois MISR
//   signature. The final signature is the single word to compare between runs.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     one-cycle pulse that begins a run (accepted in IDLE and DONE)
//   num_vecs  run length, sampled when start is accepted
//   in_valid  a result vector is present on in_data
//   in_data   result bus
//   in_ready  vector accepted this cycle when in_valid is also high
//   vec_cnt   vectors accepted in the current run
//   busy      run in progress
//   done      run complete, sig is final
//   sig       current signature
module out_data_sig_capture #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED = 32'hFFFFFFFF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vecs,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  sig
);

  localparam int unsigned NSLICE = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PAD_W  = NSLICE * SIG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [SIG_W-1:0]   sig_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W-1:0]   target, target_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic [PAD_W-1:0]   padded;
  logic [SIG_W-1:0]   fold;
  logic               accept;

  assign in_ready = (state == ACCUM);
  assign busy     = (state == ACCUM);
  assign done     = (state == DONE);
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = vec_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // Zero-pad the bus to whole slices and XOR the slices together.
  always_comb begin
    padded = '0;
    padded[DATA_W-1:0] = in_data;
    fold = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      fold = fold ^ padded[i*SIG_W +: SIG_W];
    end
  end

  always_comb begin
    state_next  = state;
    sig_next    = sig;
    cnt_next    = vec_cnt;
    target_next = target;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          target_next = num_vecs;
          sig_next    = SEED;
          cnt_next    = '0;
          state_next  = (num_vecs == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
          cnt_next = cnt_inc;
          if (cnt_inc == target) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sig     <= SEED;
      vec_cnt <= '0;
      target  <= '0;
    end else begin
      state   <= state_next;
      sig     <= sig_next;
      vec_cnt <= cnt_next;
      target  <= target_next;
    end
  end

endmodule

// File: tb/tb_out_data_sig_capture.sv
// Directed bench for out_data_sig_capture. A default-seed instance and a
// SEED=0 instance share one stimulus stream; the zero-seed copy makes the
// fold/shift arithmetic visible without the seed mixing in.
module tb_out_data_sig_capture;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_vecs = '0;
  logic        in_valid = 1'b0;
  logic [95:0] in_data = '0;

  logic        in_ready, busy, done;
  logic [15:0] vec_cnt;
  logic [31:0] sig;
  logic        in_ready0, busy0, done0;
  logic [15:0] vec_cnt0;
  logic [31:0] sig0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  out_data_sig_capture u_dut (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .vec_cnt(vec_cnt), .busy(busy), .done(done), .sig(sig)
  );

  out_data_sig_capture #(.SEED(32'h0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .vec_cnt(vec_cnt0), .busy(busy0), .done(done0), .sig(sig0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] step(input logic [31:0] s, input logic [95:0] d);
    logic [31:0] f;
    f = d[95:64] ^ d[63:32] ^ d[31:0];
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  logic [95:0] dv [5];
  logic [31:0] m;

  initial begin
    dv[0] = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    dv[1] = 96'hDEAD_BEEF_0000_FFFF_1234_5678;
    dv[2] = 96'h8000_0000_0000_0001_7FFF_FFFF;
    dv[3] = 96'hA5A5_A5A5_5A5A_5A5A_C3C3_3C3C;
    dv[4] = 96'h0000_0001_0000_0002_0000_0004;

    // Reset held two cycles, then idle.
    tick(); tick();
    rst = 1'b0;
    check("rst_sig", sig, SEED);
    check("rst_cnt", 32'(vec_cnt), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b1; in_data = 96'h5;
    tick();
    check("idle_sig", sig, SEED);
    check("idle_cnt", 32'(vec_cnt), 32'd0);
    in_valid = 1'b0;

    // Single zero vector.
    start = 1'b1; num_vecs = 16'd1;
    tick();
    start = 1'b0;
    check("one_ready", 32'(in_ready), 32'd1);
    check("one_busy", 32'(busy), 32'd1);
    check("one_done_early", 32'(done), 32'd0);
    in_valid = 1'b1; in_data = '0;
    tick();
    in_valid = 1'b0;
    check("one_sig", sig, 32'hFB3EE249);
    check("one_cnt", 32'(vec_cnt), 32'd1);
    check("one_done", 32'(done), 32'd1);
    check("one_ready_off", 32'(in_ready), 32'd0);
    tick();
    check("one_hold_sig", sig, 32'hFB3EE249);

    // Fold/shift with zero seed.
    start = 1'b1; num_vecs = 16'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 96'h1;
    tick();
    check("fs_sig1", sig0, 32'h1);
    check("fs_done_mid", 32'(done0), 32'd0);
    in_data = 96'h0;
    tick();
    in_valid = 1'b0;
    check("fs_sig2", sig0, 32'h2);
    check("fs_done", 32'(done0), 32'd1);
    start = 1'b1; num_vecs = 16'd1;
    tick();
    start = 1'b0;
    check("fs_restart_done", 32'(done0), 32'd0);
    check("fs_restart_ready", 32'(in_ready0), 32'd1);
    in_valid = 1'b1; in_data = {32'hA, 32'hA, 32'h3};
    tick();
    in_valid = 1'b0;
    check("fs_fold", sig0, 32'h3);
    check("fs_fold_done", 32'(done0), 32'd1);

    // Gap-free reference run of three vectors.
    m = SEED;
    for (int i = 0; i < 3; i++) m = step(m, dv[i]);
    start = 1'b1; num_vecs = 16'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = dv[i];
      tick();
    end
    in_valid = 1'b0;
    check("nogap_sig", sig, m);
    check("nogap_done", 32'(done), 32'd1);

    // Same data with gaps and start pulses in the gaps.
    start = 1'b1; num_vecs = 16'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = dv[0]; tick();
    in_valid = 1'b0; start = 1'b1; num_vecs = 16'd7; in_data = dv[3]; tick();
    check("gap_hold_cnt", 32'(vec_cnt), 32'd1);
    check("gap_hold_sig", sig, step(SEED, dv[0]));
    in_valid = 1'b1; start = 1'b0; in_data = dv[1]; tick();
    in_valid = 1'b0; start = 1'b1; in_data = dv[4]; tick();
    start = 1'b0;
    check("gap_busy", 32'(busy), 32'd1);
    in_valid = 1'b1; in_data = dv[2]; tick();
    in_valid = 1'b0;
    check("gap_cnt", 32'(vec_cnt), 32'd3);
    check("gap_sig", sig, m);
    check("gap_done", 32'(done), 32'd1);
    in_valid = 1'b1; in_data = dv[4]; tick();
    in_valid = 1'b0;
    check("done_ignore_sig", sig, m);
    check("done_ignore_cnt", 32'(vec_cnt), 32'd3);

    // Zero-length run, then restart from DONE.
    start = 1'b1; num_vecs = 16'd0;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_sig", sig, SEED);
    check("zero_cnt", 32'(vec_cnt), 32'd0);
    check("zero_ready", 32'(in_ready), 32'd0);
    start = 1'b1; num_vecs = 16'd1;
    tick();
    start = 1'b0;
    check("rs_done", 32'(done), 32'd0);
    check("rs_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = dv[3];
    tick();
    in_valid = 1'b0;
    check("rs_cnt", 32'(vec_cnt), 32'd1);
    check("rs_sig", sig, step(SEED, dv[3]));

    // Reset mid-run.
    start = 1'b1; num_vecs = 16'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = dv[0]; tick();
    in_data = dv[1]; tick();
    check("mid_cnt", 32'(vec_cnt), 32'd2);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_sig", sig, SEED);
    check("mid_rst_cnt", 32'(vec_cnt), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = dv[2]; tick();
    in_valid = 1'b0;
    check("mid_idle_done", 32'(done), 32'd0);
    check("mid_idle_sig", sig, SEED);

    // Full clean run afterwards.
    m = SEED;
    for (int i = 0; i < 5; i++) m = step(m, dv[i]);
    start = 1'b1; num_vecs = 16'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = dv[i];
      tick();
    end
    in_valid = 1'b0;
    check("full_sig", sig, m);
    check("full_cnt", 32'(vec_cnt), 32'd5);
    check("full_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
